mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit of the MIPS execute stage; owns the HI/LO architectural registers.
- Its o_hi/o_lo outputs feed the execute-stage result select mux (MFHI/MFLO paths).
- o_busy drives the hazard/stall logic upstream.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
BIT, 32, operand and HI/LO width; must be even and >= 4.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  request; accepted only when o_busy=0
i_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
i_a  in  BIT  rs operand (multiplicand/dividend/MTxx data)
i_b  in  BIT  rt operand (multiplier/divisor)
i_cancel  in  1  pipeline flush; aborts a running op
o_hi  out  BIT  HI register
o_lo  out  BIT  LO register
o_busy  out  1  multi-cycle op in progress
o_done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV

Behaviour:
- Reset (async, i_rst_n=0): o_hi=0, o_lo=0, o_busy=0, o_done=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately; no partial HI/LO write.
- FSM states: IDLE, RUN, FIX.
- IDLE: i_start && op in 0-3 at edge E0:
  - latch operand magnitudes (absolute values for signed ops) and the result sign flags
  - counter=BIT-1
  - go to RUN; o_busy=1 from E0.
- IDLE: i_start && op 4/5: HI (or LO) <= i_a at E0; no busy, no o_done.
- IDLE: op 6/7: ignored.
- RUN: one iteration per cycle; counter decrements. When counter==0, go to FIX. RUN lasts BIT cycles (E0..E_BIT).
- FIX:
  - apply sign correction
  - write HI/LO at E_BIT+1
  - o_busy falls and o_done rises at E_BIT+1
  - o_done falls at E_BIT+2
  - total latency BIT+1 cycles (33 for BIT=32).
- MULT/MULTU: {HI,LO} = full 2*BIT-bit product, two's complement for MULT.
- DIV/DIVU:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - DIV of -2^(BIT-1) by -1: LO=0x80000000, HI=0 (no trap).
- Divide by zero (signed or unsigned): LO=all ones, HI=i_a as latched; latency unchanged.
- i_start while o_busy=1 is ignored (any op, including MTHI/MTLO); the stall logic must hold the instruction.
- i_cancel in RUN or FIX: return to IDLE next edge; o_busy=0; HI/LO unchanged; no o_done.
- i_cancel in IDLE with i_start: the request is dropped.
- i_cancel has priority over a FIX-cycle write.
- o_hi/o_lo are direct register outputs, stable throughout RUN (they hold the previous result).

Optional Feature:
- Macro MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational multiplier; HI/LO written and o_done pulsed at E0+1.
  - o_busy is high only during the E0..E0+1 cycle.
  - DIV/DIVU are unchanged.
- Undefined: iterative multiply, BIT+1-cycle latency as above.
- Division behaviour is identical in both builds.

Decomposition:
- Package mdu_pkg:
  - op encoding constants (OP_MULT..OP_MTLO)
  - FSM state typedef (IDLE/RUN/FIX)
  - MDU_LAT constant = BIT+1.
- One natural sub-module, mdu_iter_step: combinational single iteration. Add-or-pass for multiply; trial-subtract/restore for divide. Inputs: partial remainder/product, operand, mode. Outputs: next partial state and quotient bit.
- The FSM, counter, sign handling and HI/LO registers stay in mult_div_unit.

Test Plan:
- Reset then MTHI i_a=0x12345678, next cycle MTLO i_a=0x9ABCDEF0 -> o_hi=0x12345678 and o_lo=0x9ABCDEF0, each one edge after its request; o_busy stays 0.
- MULT a=0xFFFFFFFF(-1), b=0x00000003 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFD, o_done one cycle. Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFD.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU a=7, b=2 -> LO=3, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5.
- During RUN: new i_start (MTLO) at cycle 5 -> ignored. Assert i_cancel at cycle 10 -> o_busy=0 next edge, HI/LO keep prior values, no o_done.
- Drive i_rst_n low at cycle 20 of a DIV -> all outputs 0 asynchronously. After release, MULTU 3*4 -> LO=12, HI=0. With MDU_FAST_MULT_EN -> same result after one cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and latency.
package mdu_pkg;

  localparam int MDU_BIT = 32;
  localparam int MDU_LAT = MDU_BIT + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // True for the multi-cycle arithmetic ops (MULT, MULTU, DIV, DIVU).
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int BIT = MDU_BIT
) (
  input  logic [BIT-1:0] hi_in,
  input  logic [BIT-1:0] lo_in,
  input  logic [BIT-1:0] opnd,
  input  logic           is_div,
  output logic [BIT-1:0] hi_out,
  output logic [BIT-1:0] lo_out,
  output logic           q_bit
);

  logic [BIT:0] sum_s;
  logic [BIT:0] shifted_s;
  logic         ge_s;

  // Multiply keeps {hi,lo} as accumulator:multiplier; divide keeps remainder:dividend.
  always_comb begin
    sum_s     = {1'b0, hi_in} + {1'b0, (lo_in[0] ? opnd : {BIT{1'b0}})};
    shifted_s = {hi_in, lo_in[BIT-1]};
    ge_s      = (shifted_s >= {1'b0, opnd});
    if (is_div) begin
      q_bit  = ge_s;
      hi_out = ge_s ? BIT'(shifted_s - {1'b0, opnd}) : shifted_s[BIT-1:0];
      lo_out = {lo_in[BIT-2:0], 1'b0};
    end else begin
      q_bit  = 1'b0;
      hi_out = sum_s[BIT:1];
      lo_out = {sum_s[0], lo_in[BIT-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit, one bit per cycle on unsigned magnitudes.
// Define MDU_FAST_MULT_EN for a single-cycle combinational multiply path.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int BIT = MDU_BIT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [2:0]     i_op,
  input  logic [BIT-1:0] i_a,
  input  logic [BIT-1:0] i_b,
  input  logic           i_cancel,
  output logic [BIT-1:0] o_hi,
  output logic [BIT-1:0] o_lo,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CW = $clog2(BIT);

  mdu_state_e       state_r;
  logic [CW-1:0]    cnt_r;
  logic [BIT-1:0]   acc_hi_r;
  logic [BIT-1:0]   acc_lo_r;
  logic [BIT-1:0]   opnd_r;
  logic [BIT-1:0]   a_raw_r;
  logic [BIT-1:0]   hi_r;
  logic [BIT-1:0]   lo_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div_zero_r;
  logic             busy_r;
  logic             done_r;

  logic             is_mul_s;
  logic             is_signed_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [BIT-1:0]   mag_a_s;
  logic [BIT-1:0]   mag_b_s;
  logic [BIT-1:0]   step_hi_s;
  logic [BIT-1:0]   step_lo_s;
  logic             step_q_s;
  logic [2*BIT-1:0] mul_res_s;
  logic [BIT-1:0]   quo_s;
  logic [BIT-1:0]   rem_s;
  logic [BIT-1:0]   fix_hi_s;
  logic [BIT-1:0]   fix_lo_s;

  // Decode request and convert signed operands to magnitudes.
  always_comb begin
    is_mul_s    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    is_signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);
    sign_a_s    = is_signed_s & i_a[BIT-1];
    sign_b_s    = is_signed_s & i_b[BIT-1];
    mag_a_s     = sign_a_s ? (~i_a + BIT'(1)) : i_a;
    mag_b_s     = sign_b_s ? (~i_b + BIT'(1)) : i_b;
  end

`ifdef MDU_FAST_MULT_EN
  logic [2*BIT-1:0] fast_prod_s;

  // Full-width unsigned product of the magnitudes in one cycle.
  always_comb begin
    fast_prod_s = (2*BIT)'(mag_a_s) * (2*BIT)'(mag_b_s);
  end
`endif

  mdu_iter_step #(
    .BIT(BIT)
  ) u_step (
    .hi_in (acc_hi_r),
    .lo_in (acc_lo_r),
    .opnd  (opnd_r),
    .is_div(is_div_r),
    .hi_out(step_hi_s),
    .lo_out(step_lo_s),
    .q_bit (step_q_s)
  );

  // Sign correction and divide-by-zero override for the FIX write.
  always_comb begin
    mul_res_s = neg_q_r ? (~{acc_hi_r, acc_lo_r} + (2*BIT)'(1)) : {acc_hi_r, acc_lo_r};
    quo_s     = neg_q_r ? (~acc_lo_r + BIT'(1)) : acc_lo_r;
    rem_s     = neg_r_r ? (~acc_hi_r + BIT'(1)) : acc_hi_r;
    if (!is_div_r) begin
      fix_hi_s = mul_res_s[2*BIT-1:BIT];
      fix_lo_s = mul_res_s[BIT-1:0];
    end else if (div_zero_r) begin
      fix_hi_s = a_raw_r;
      fix_lo_s = {BIT{1'b1}};
    end else begin
      fix_hi_s = rem_s;
      fix_lo_s = quo_s;
    end
  end

  // Control FSM, iteration datapath and HI/LO architectural registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      acc_hi_r   <= {BIT{1'b0}};
      acc_lo_r   <= {BIT{1'b0}};
      opnd_r     <= {BIT{1'b0}};
      a_raw_r    <= {BIT{1'b0}};
      hi_r       <= {BIT{1'b0}};
      lo_r       <= {BIT{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start && !i_cancel) begin
            if (is_arith_op(i_op)) begin
              busy_r     <= 1'b1;
              cnt_r      <= CW'(BIT - 1);
              is_div_r   <= !is_mul_s;
              neg_q_r    <= sign_a_s ^ sign_b_s;
              neg_r_r    <= sign_a_s;
              div_zero_r <= !is_mul_s && (i_b == {BIT{1'b0}});
              a_raw_r    <= i_a;
              opnd_r     <= is_mul_s ? mag_a_s : mag_b_s;
`ifdef MDU_FAST_MULT_EN
              if (is_mul_s) begin
                {acc_hi_r, acc_lo_r} <= fast_prod_s;
                state_r              <= FIX;
              end else begin
                acc_hi_r <= {BIT{1'b0}};
                acc_lo_r <= mag_a_s;
                state_r  <= RUN;
              end
`else
              acc_hi_r <= {BIT{1'b0}};
              acc_lo_r <= is_mul_s ? mag_b_s : mag_a_s;
              state_r  <= RUN;
`endif
            end else if (i_op == OP_MTHI) begin
              hi_r <= i_a;
            end else if (i_op == OP_MTLO) begin
              lo_r <= i_a;
            end
          end
        end
        RUN: begin
          if (i_cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s | {{(BIT-1){1'b0}}, step_q_s};
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == {CW{1'b0}}) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          if (!i_cancel) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_hi   = hi_r;
  assign o_lo   = lo_r;
  assign o_busy = busy_r;
  assign o_done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (BIT=32), both multiply builds.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_cancel;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  int total;
  int bad;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  int mul_lat;

  mult_div_unit #(.BIT(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cancel(i_cancel),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one rising edge (E0); returns at the negedge after E0.
  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int cyc;
    req(op, a, b);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
    check({tag, "_hold"}, {o_hi, o_lo}, {cur_hi, cur_lo});
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_hilo"}, {o_hi, o_lo}, {eh, el});
    check({tag, "_busy_end"}, {63'd0, o_busy}, 64'd0);
    @(negedge i_clk);
    check({tag, "_done_pulse"}, {63'd0, o_done}, 64'd0);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    int seen;
    total    = 0;
    bad      = 0;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_op     = 3'd0;
    i_a      = 32'd0;
    i_b      = 32'd0;
    i_cancel = 1'b0;
    cur_hi   = 32'd0;
    cur_lo   = 32'd0;
`ifdef MDU_FAST_MULT_EN
    mul_lat = 1;
`else
    mul_lat = MDU_LAT;
`endif
    #12;
    check("rst_hilo", {o_hi, o_lo}, 64'd0);
    check("rst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // MTHI / MTLO back to back
    req(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi_hi", {32'd0, o_hi}, 64'h12345678);
    check("mthi_busy", {63'd0, o_busy}, 64'd0);
    i_start = 1'b1;
    i_op    = OP_MTLO;
    i_a     = 32'h9ABCDEF0;
    @(negedge i_clk);
    i_start = 1'b0;
    check("mtlo_hilo", {o_hi, o_lo}, 64'h12345678_9ABCDEF0);
    check("mtlo_busy", {63'd0, o_busy}, 64'd0);
    cur_hi = 32'h12345678;
    cur_lo = 32'h9ABCDEF0;

    run_op("mult_neg", OP_MULT, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFD, mul_lat);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h3, 32'h00000002, 32'hFFFFFFFD, mul_lat);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, MDU_LAT);
    run_op("divu", OP_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, MDU_LAT);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, MDU_LAT);
    run_op("divu_zero", OP_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, MDU_LAT);
    run_op("div_zero", OP_DIV, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, MDU_LAT);
    run_op("mult_mix", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6, mul_lat);
    run_op("div_rem", OP_DIV, 32'h00000064, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFF2, MDU_LAT);

    // MTLO while busy is ignored; cancel aborts without writing
    req(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge i_clk);
    i_start = 1'b1;
    i_op    = OP_MTLO;
    i_a     = 32'hDEADBEEF;
    @(negedge i_clk);
    i_start = 1'b0;
    check("busy_mtlo_ignored", {o_hi, o_lo}, {cur_hi, cur_lo});
    check("busy_mid_run", {63'd0, o_busy}, 64'd1);
    repeat (4) @(negedge i_clk);
    i_cancel = 1'b1;
    @(negedge i_clk);
    i_cancel = 1'b0;
    check("cancel_busy", {63'd0, o_busy}, 64'd0);
    check("cancel_hilo", {o_hi, o_lo}, {cur_hi, cur_lo});
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done === 1'b1) seen = 1;
    end
    check("cancel_no_done", 64'(seen), 64'd0);
    check("cancel_hilo_late", {o_hi, o_lo}, {cur_hi, cur_lo});

    // Cancel together with a request in IDLE drops it; no-op is ignored
    @(negedge i_clk);
    i_start  = 1'b1;
    i_op     = OP_MTHI;
    i_a      = 32'h55555555;
    i_cancel = 1'b1;
    @(negedge i_clk);
    i_start  = 1'b0;
    i_cancel = 1'b0;
    check("idle_cancel_drop", {o_hi, o_lo}, {cur_hi, cur_lo});
    req(3'd6, 32'hAAAAAAAA, 32'h1);
    check("noop_hilo", {o_hi, o_lo}, {cur_hi, cur_lo});
    check("noop_busy", {63'd0, o_busy}, 64'd0);

    // Asynchronous reset in the middle of a divide
    req(OP_DIV, 32'hFFFFFF00, 32'd3);
    repeat (19) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_hilo", {o_hi, o_lo}, 64'd0);
    check("arst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    run_op("multu_post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, mul_lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
